// File: rtl/cordic_result_buffer_pkg.sv
// cordic_result_buffer_pkg: shared CORDIC types, default sample width and level sizing
package cordic_result_buffer_pkg;

   localparam int CORDIC_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      ACTIVE = 2'd1,
      FULL   = 2'd2
   } state_e;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cordic_result_mem.sv
// cordic_result_mem: DEPTH x W register array, one synchronous write port, one combinational read port
module cordic_result_mem #(
   parameter int DEPTH = 32,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // storage is deliberately not reset; validity is tracked by the pointers in the parent
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cordic_result_buffer.sv
// cordic_result_buffer: FWFT FIFO for CORDIC sine/cosine pairs with registered head, almost_full and sticky overflow
module cordic_result_buffer
   import cordic_result_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = CORDIC_DATA_WIDTH,
   parameter int DEPTH      = 32,
   parameter int AF_LEVEL   = 12
) (
   input  logic                              clk,
   input  logic                              arst_n,
   input  logic                              valid_in,
   input  logic [DATA_WIDTH-1:0]             sine_in,
   input  logic [DATA_WIDTH-1:0]             cosine_in,
   input  logic                              ready_in,
   output logic                              valid_out,
   output logic [DATA_WIDTH-1:0]             sine_out,
   output logic [DATA_WIDTH-1:0]             cosine_out,
   output logic                              almost_full,
   output logic                              overflow,
   input  logic                              clear_ovf,
   output logic [level_width(DEPTH)-1:0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);
   localparam int W  = 2 * DATA_WIDTH;

   state_e        state_q, state_d;
   logic [LW-1:0] level_q, level_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [W-1:0]  out_q, out_d, mem_rdata;
   logic          af_q, af_d, ovf_q, ovf_d;
   logic          full, push, pop, drop, load_out, mem_empty, mem_we;

   // datapath: the output register holds the head, the array holds everything behind it
   always_comb begin
      full      = level_q == LW'(DEPTH);
      pop       = (state_q != EMPTY) && ready_in;
      push      = valid_in && (!full || pop);
      drop      = valid_in && full && !pop;
      load_out  = pop || (state_q == EMPTY);
      mem_empty = level_q < LW'(2);
      mem_we    = push && !(load_out && mem_empty);
      wr_ptr_d  = mem_we ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = (load_out && !mem_empty) ? rd_ptr_q + AW'(1) : rd_ptr_q;
      out_d     = !load_out ? out_q : !mem_empty ? mem_rdata : push ? {sine_in, cosine_in} : out_q;
      level_d   = level_q + LW'(push) - LW'(pop);
      af_d      = (LW'(DEPTH) - level_d) <= LW'(AF_LEVEL);
      ovf_d     = drop || (ovf_q && !clear_ovf);
   end

   // control FSM: EMPTY means no head, FULL means level reached DEPTH
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   state_d = push ? ACTIVE : EMPTY;
         ACTIVE:  begin
            if (pop && !push && level_q == LW'(1)) state_d = EMPTY;
            else if (push && !pop && level_q == LW'(DEPTH - 1)) state_d = FULL;
         end
         FULL:    state_d = (pop && !push) ? ACTIVE : FULL;
         default: state_d = EMPTY;
      endcase
   end

   // all control and output state clears asynchronously so reset discards every entry
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= EMPTY;
         level_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         out_q    <= '0;
         af_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         out_q    <= out_d;
         af_q     <= af_d;
         ovf_q    <= ovf_d;
      end
   end

   cordic_result_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i ({sine_in, cosine_in}),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

   assign valid_out               = state_q != EMPTY;
   assign {sine_out, cosine_out}  = out_q;
   assign level                   = level_q;
   assign almost_full             = af_q;
   assign overflow                = ovf_q;

endmodule
